// File: rtl/uart_alu_runner_if.sv
// uart_alu_runner_if: serial pin bundle between a board UART and the packet
// processor.
//   rx_i : serial line into the processor, idle high.
//   tx_o : serial line out of the processor, idle high.
// The slave modport is the processor side. The master modport is the
// board/host side.
interface uart_alu_runner_if;
    logic rx_i;
    logic tx_o;

    modport slave  (input rx_i, output tx_o);
    modport master (output rx_i, input tx_o);
endinterface

// File: rtl/uart_alu_runner.sv
// uart_alu_runner: UART-attached packet processor.
// It receives framed command packets (opcode, reserved, len_lo, len_hi,
// payload). It then either echoes the payload or runs a 32-bit unsigned
// ADD / MUL / DIV over little-endian operands, and sends the result bytes
// back over the serial TX line.
// Ports:
//   clk_i   : system clock, rising edge.
//   reset_i : synchronous active-high reset.
//   uart    : serial pins (rx_i in, tx_o out), 8N1, LSB first, idle high.
module uart_alu_runner #(
    parameter int CLK_FREQ_HZ   = 100000000,
    parameter int BAUD_RATE     = 115200,
    parameter int TX_FIFO_DEPTH = 16
) (
    input  logic             clk_i,
    input  logic             reset_i,
    uart_alu_runner_if.slave uart
);

    localparam int BIT_CYC = CLK_FREQ_HZ / BAUD_RATE;
    localparam int CW      = $clog2(BIT_CYC) + 1;
    localparam int AW      = $clog2(TX_FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(BIT_CYC - 1);
    // The edge detector adds one cycle, so the check lands at BIT_CYC/2.
    localparam logic [CW-1:0] HALF_LAST = CW'(BIT_CYC / 2 - 1);

    localparam logic [7:0] OP_ECHO = 8'hEC;
    localparam logic [7:0] OP_ADD  = 8'hA0;
    localparam logic [7:0] OP_MUL  = 8'hA1;
    localparam logic [7:0] OP_DIV  = 8'hA2;

    // ---------------- RX: synchronizer and deserializer ----------------
    typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH} rx_state_e;
    rx_state_e     rx_state_q, rx_state_d;
    logic          rx_meta_q, rx_sync_q, rx_prev_q;
    logic [CW-1:0] rx_cnt_q, rx_cnt_d;
    logic [2:0]    rx_bit_q, rx_bit_d;
    logic [7:0]    rx_shift_q, rx_shift_d;
    logic          rx_done;
    // A one-byte holding register lets RX keep running while the parser
    // is busy computing or responding.
    logic [7:0]    rx_byte_q, rx_byte_d;
    logic          rx_pend_q, rx_pend_d;
    logic          rx_take;

    always_comb begin
        rx_state_d = rx_state_q;
        rx_cnt_d   = rx_cnt_q + CW'(1);
        rx_bit_d   = rx_bit_q;
        rx_shift_d = rx_shift_q;
        rx_done    = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                rx_cnt_d = '0;
                if (rx_prev_q && !rx_sync_q) rx_state_d = RX_START;
            end
            RX_START: begin
                if (rx_cnt_q == HALF_LAST) begin
                    rx_cnt_d   = '0;
                    rx_bit_d   = '0;
                    rx_state_d = rx_sync_q ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d   = '0;
                    rx_shift_d = {rx_sync_q, rx_shift_q[7:1]};
                    rx_bit_d   = rx_bit_q + 3'd1;
                    if (rx_bit_q == 3'd7) rx_state_d = RX_STOP;
                end
            end
            RX_STOP: begin
                if (rx_cnt_q == BIT_LAST) begin
                    rx_cnt_d = '0;
                    if (rx_sync_q) begin
                        rx_done    = 1'b1;
                        rx_state_d = RX_IDLE;
                    end else begin
                        rx_state_d = RX_WAIT_HIGH;
                    end
                end
            end
            RX_WAIT_HIGH: begin
                rx_cnt_d = '0;
                if (rx_sync_q) rx_state_d = RX_IDLE;
            end
            default: rx_state_d = RX_IDLE;
        endcase

        rx_byte_d = rx_done ? rx_shift_q : rx_byte_q;
        rx_pend_d = rx_done ? 1'b1 : (rx_take ? 1'b0 : rx_pend_q);
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rx_meta_q  <= 1'b1;
            rx_sync_q  <= 1'b1;
            rx_prev_q  <= 1'b1;
            rx_state_q <= RX_IDLE;
            rx_cnt_q   <= '0;
            rx_bit_q   <= '0;
            rx_shift_q <= '0;
            rx_byte_q  <= '0;
            rx_pend_q  <= 1'b0;
        end else begin
            rx_meta_q  <= uart.rx_i;
            rx_sync_q  <= rx_meta_q;
            rx_prev_q  <= rx_sync_q;
            rx_state_q <= rx_state_d;
            rx_cnt_q   <= rx_cnt_d;
            rx_bit_q   <= rx_bit_d;
            rx_shift_q <= rx_shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_pend_q  <= rx_pend_d;
        end
    end

    // ---------------- TX FIFO ----------------
    logic [7:0]  fifo_mem [TX_FIFO_DEPTH];
    logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic        fifo_empty, fifo_full;
    logic [7:0]  fifo_rdata;
    logic        push, tx_load;
    logic [7:0]  push_data;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_rdata = fifo_mem[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = push    ? wr_ptr_q + (AW+1)'(1) : wr_ptr_q;
        rd_ptr_d = tx_load ? rd_ptr_q + (AW+1)'(1) : rd_ptr_q;
    end

    always_ff @(posedge clk_i) begin
        if (push) fifo_mem[wr_ptr_q[AW-1:0]] <= push_data;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // ---------------- TX serializer ----------------
    // The frame shifts out of bit 0, so the line itself is a flop.
    // The next byte is loaded in the same cycle the stop bit ends, which
    // keeps frames back-to-back.
    logic [9:0]    tx_shift_q, tx_shift_d;
    logic [3:0]    tx_bits_q, tx_bits_d;
    logic [CW-1:0] tx_cnt_q, tx_cnt_d;
    logic          tx_busy_q, tx_busy_d;
    logic          tx_frame_end;

    always_comb begin
        tx_shift_d   = tx_shift_q;
        tx_bits_d    = tx_bits_q;
        tx_cnt_d     = tx_cnt_q;
        tx_busy_d    = tx_busy_q;
        tx_load      = 1'b0;
        tx_frame_end = tx_busy_q && (tx_cnt_q == BIT_LAST) && (tx_bits_q == 4'd9);
        if (tx_busy_q) begin
            if (tx_cnt_q == BIT_LAST) begin
                tx_cnt_d = '0;
                if (tx_bits_q == 4'd9) begin
                    tx_busy_d  = 1'b0;
                    tx_shift_d = '1;
                end else begin
                    tx_shift_d = {1'b1, tx_shift_q[9:1]};
                    tx_bits_d  = tx_bits_q + 4'd1;
                end
            end else begin
                tx_cnt_d = tx_cnt_q + CW'(1);
            end
        end
        if ((!tx_busy_q || tx_frame_end) && !fifo_empty) begin
            tx_load    = 1'b1;
            tx_busy_d  = 1'b1;
            tx_shift_d = {1'b1, fifo_rdata, 1'b0};
            tx_bits_d  = '0;
            tx_cnt_d   = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            tx_shift_q <= '1;
            tx_bits_q  <= '0;
            tx_cnt_q   <= '0;
            tx_busy_q  <= 1'b0;
        end else begin
            tx_shift_q <= tx_shift_d;
            tx_bits_q  <= tx_bits_d;
            tx_cnt_q   <= tx_cnt_d;
            tx_busy_q  <= tx_busy_d;
        end
    end

    assign uart.tx_o = tx_shift_q[0];

    // ---------------- Packet parser and ALU ----------------
    typedef enum logic [2:0] {
        P_OPCODE, P_RESERVED, P_LEN_LO, P_LEN_HI,
        P_PAYLOAD, P_COMPUTE, P_RESPOND, P_DISCARD
    } p_state_e;
    p_state_e    p_state_q, p_state_d;
    logic [7:0]  op_q, op_d;
    logic [15:0] len_q, len_d, idx_q, idx_d;
    logic [23:0] opnd_q, opnd_d;     // first three bytes of the operand being assembled
    logic [31:0] acc_q, acc_d;       // ADD/MUL accumulator; dividend A for DIV
    logic [31:0] opb_q, opb_d;       // divisor B
    logic [31:0] rem_q, rem_d, quot_q, quot_d;
    logic [4:0]  div_cnt_q, div_cnt_d;
    logic        div_run_q, div_run_d;
    logic [63:0] resp_q, resp_d;
    logic [3:0]  resp_left_q, resp_left_d;

    logic [31:0] opnd_full;
    logic [15:0] len_full;
    logic [32:0] div_shift;
    logic        div_ge;
    logic [31:0] rem_next, quot_next;
    logic        op_known;

    always_comb begin
        p_state_d   = p_state_q;
        op_d        = op_q;
        len_d       = len_q;
        idx_d       = idx_q;
        opnd_d      = opnd_q;
        acc_d       = acc_q;
        opb_d       = opb_q;
        rem_d       = rem_q;
        quot_d      = quot_q;
        div_cnt_d   = div_cnt_q;
        div_run_d   = div_run_q;
        resp_d      = resp_q;
        resp_left_d = resp_left_q;
        rx_take     = 1'b0;
        push        = 1'b0;
        push_data   = rx_byte_q;

        opnd_full = {rx_byte_q, opnd_q};
        len_full  = {rx_byte_q, len_q[7:0]};
        op_known  = (op_q == OP_ECHO) || (op_q == OP_ADD) ||
                    (op_q == OP_MUL)  || (op_q == OP_DIV);
        // One restoring-division step. When the trial subtraction succeeds,
        // the true difference is below B, so 32-bit wraparound arithmetic
        // gives the exact remainder.
        div_shift = {rem_q, quot_q[31]};
        div_ge    = (div_shift >= {1'b0, opb_q});
        rem_next  = div_ge ? (div_shift[31:0] - opb_q) : div_shift[31:0];
        quot_next = {quot_q[30:0], div_ge};

        case (p_state_q)
            P_OPCODE: begin
                if (rx_pend_q) begin
                    rx_take   = 1'b1;
                    op_d      = rx_byte_q;
                    p_state_d = P_RESERVED;
                end
            end
            P_RESERVED: begin
                if (rx_pend_q) begin
                    rx_take   = 1'b1;
                    p_state_d = P_LEN_LO;
                end
            end
            P_LEN_LO: begin
                if (rx_pend_q) begin
                    rx_take   = 1'b1;
                    len_d     = {len_q[15:8], rx_byte_q};
                    p_state_d = P_LEN_HI;
                end
            end
            P_LEN_HI: begin
                if (rx_pend_q) begin
                    rx_take = 1'b1;
                    len_d   = len_full;
                    idx_d   = '0;
                    opnd_d  = '0;
                    opb_d   = '0;
                    acc_d   = (op_q == OP_MUL) ? 32'd1 : 32'd0;
                    if (!op_known)
                        p_state_d = (len_full == 16'd0) ? P_OPCODE : P_DISCARD;
                    else if (len_full == 16'd0)
                        p_state_d = (op_q == OP_ECHO) ? P_OPCODE : P_COMPUTE;
                    else
                        p_state_d = P_PAYLOAD;
                end
            end
            P_PAYLOAD: begin
                // Echo holds the byte while the FIFO is full; ALU ops never push here.
                if (rx_pend_q && (op_q != OP_ECHO || !fifo_full)) begin
                    rx_take = 1'b1;
                    idx_d   = idx_q + 16'd1;
                    opnd_d  = opnd_full[31:8];
                    if (op_q == OP_ECHO) begin
                        push = 1'b1;
                    end else if (idx_q[1:0] == 2'd3) begin
                        case (op_q)
                            OP_ADD:  acc_d = acc_q + opnd_full;
                            OP_MUL:  acc_d = acc_q * opnd_full;
                            default: begin
                                if (idx_q[15:2] == 14'd0)      acc_d = opnd_full;
                                else if (idx_q[15:2] == 14'd1) opb_d = opnd_full;
                            end
                        endcase
                    end
                    if (idx_q + 16'd1 == len_q)
                        p_state_d = (op_q == OP_ECHO) ? P_OPCODE : P_COMPUTE;
                end
            end
            P_COMPUTE: begin
                if (op_q == OP_DIV) begin
                    if (!div_run_q) begin
                        div_run_d = 1'b1;
                        rem_d     = '0;
                        quot_d    = acc_q;
                        div_cnt_d = '0;
                    end else begin
                        rem_d     = rem_next;
                        quot_d    = quot_next;
                        div_cnt_d = div_cnt_q + 5'd1;
                        if (div_cnt_q == 5'd31) begin
                            div_run_d   = 1'b0;
                            resp_d      = {quot_next, rem_next};
                            resp_left_d = 4'd8;
                            p_state_d   = P_RESPOND;
                        end
                    end
                end else begin
                    resp_d      = {32'd0, acc_q};
                    resp_left_d = 4'd4;
                    p_state_d   = P_RESPOND;
                end
            end
            P_RESPOND: begin
                if (!fifo_full) begin
                    push        = 1'b1;
                    push_data   = resp_q[7:0];
                    resp_d      = {8'd0, resp_q[63:8]};
                    resp_left_d = resp_left_q - 4'd1;
                    if (resp_left_q == 4'd1) p_state_d = P_OPCODE;
                end
            end
            P_DISCARD: begin
                if (rx_pend_q) begin
                    rx_take = 1'b1;
                    idx_d   = idx_q + 16'd1;
                    if (idx_q + 16'd1 == len_q) p_state_d = P_OPCODE;
                end
            end
            default: p_state_d = P_OPCODE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            p_state_q   <= P_OPCODE;
            op_q        <= '0;
            len_q       <= '0;
            idx_q       <= '0;
            opnd_q      <= '0;
            acc_q       <= '0;
            opb_q       <= '0;
            rem_q       <= '0;
            quot_q      <= '0;
            div_cnt_q   <= '0;
            div_run_q   <= 1'b0;
            resp_q      <= '0;
            resp_left_q <= '0;
        end else begin
            p_state_q   <= p_state_d;
            op_q        <= op_d;
            len_q       <= len_d;
            idx_q       <= idx_d;
            opnd_q      <= opnd_d;
            acc_q       <= acc_d;
            opb_q       <= opb_d;
            rem_q       <= rem_d;
            quot_q      <= quot_d;
            div_cnt_q   <= div_cnt_d;
            div_run_q   <= div_run_d;
            resp_q      <= resp_d;
            resp_left_q <= resp_left_d;
        end
    end

endmodule

// File: tb/tb_uart_alu_runner.sv
// Directed and randomized bench for uart_alu_runner at a 4-cycle bit period.
module tb_uart_alu_runner;

    localparam int BIT = 4;

    typedef logic [7:0] byte_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total  = 0;
    int   passed = 0;

    byte_t pkt[$];
    byte_t expq[$];
    byte_t rxq[$];

    uart_alu_runner_if u_if ();

    uart_alu_runner #(
        .CLK_FREQ_HZ  (400000),
        .BAUD_RATE    (100000),
        .TX_FIFO_DEPTH(16)
    ) dut (
        .clk_i  (clk),
        .reset_i(rst),
        .uart   (u_if.slave)
    );

    always #5 clk = ~clk;

    // Serial receiver on tx_o: samples near mid-bit on falling clock edges.
    initial begin
        byte_t b;
        forever begin
            @(negedge clk);
            if (!rst && u_if.tx_o === 1'b0) begin
                repeat (BIT / 2) @(negedge clk);
                if (u_if.tx_o === 1'b0) begin
                    for (int i = 0; i < 8; i++) begin
                        repeat (BIT) @(negedge clk);
                        b[i] = u_if.tx_o;
                    end
                    repeat (BIT) @(negedge clk);
                    if (u_if.tx_o === 1'b1) rxq.push_back(b);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic send_byte(input byte_t b);
        u_if.rx_i = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.rx_i = b[i];
            repeat (BIT) @(negedge clk);
        end
        u_if.rx_i = 1'b1;
        repeat (BIT) @(negedge clk);
    endtask

    task automatic expect_resp(input string tag);
        int    budget;
        byte_t got;
        budget = 0;
        while (rxq.size() < expq.size() && budget < 4000) begin
            @(negedge clk);
            budget++;
        end
        chk({tag, "_count"}, 64'(rxq.size()), 64'(expq.size()));
        foreach (expq[i]) begin
            if (rxq.size() > 0) begin
                got = rxq.pop_front();
                chk(tag, 64'(got), 64'(expq[i]));
            end
        end
    endtask

    task automatic run_pkt(input string tag);
        foreach (pkt[i]) send_byte(pkt[i]);
        expect_resp(tag);
    endtask

    task automatic expect_silence(input string tag);
        repeat (200) @(negedge clk);
        chk(tag, 64'(rxq.size()), 64'd0);
    endtask

    initial begin
        int          budget;
        int          sel, n, nops, trail;
        logic [31:0] acc, opnd, a, b, q, r;
        byte_t       rb;

        u_if.rx_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_tx_idle", 64'(u_if.tx_o), 64'd1);
        rst = 1'b0;
        repeat (10) @(negedge clk);
        chk("reset_tx_still_idle", 64'(u_if.tx_o), 64'd1);

        // One-cycle low glitch must be rejected as a false start.
        u_if.rx_i = 1'b0;
        @(negedge clk);
        u_if.rx_i = 1'b1;
        repeat (20) @(negedge clk);

        pkt = '{8'hEC, 8'h00, 8'h10, 8'h00};
        expq.delete();
        for (int i = 1; i <= 16; i++) begin
            pkt.push_back(byte_t'(i));
            expq.push_back(byte_t'(i));
        end
        run_pkt("echo16");

        pkt  = '{8'hA0, 8'h00, 8'h10, 8'h00, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
                 8'h01, 8'h00, 8'h00, 8'h80, 8'hFF, 8'hFF, 8'hFF, 8'h7F};
        expq = '{8'h01, 8'h01, 8'h00, 8'h00};
        run_pkt("add_wrap");

        pkt  = '{8'hA1, 8'h00, 8'h10, 8'h00, 8'h03, 8'h00, 8'h00, 8'h00, 8'h05, 8'h00, 8'h00, 8'h00,
                 8'h07, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        expq = '{8'h69, 8'h00, 8'h00, 8'h00};
        run_pkt("mul_105");

        pkt  = '{8'hA1, 8'h00, 8'h10, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00,
                 8'h01, 8'h00, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00};
        expq = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_pkt("mul_trunc");

        pkt  = '{8'hA2, 8'h00, 8'h08, 8'h00, 8'hC8, 8'h00, 8'h00, 8'h00, 8'h07, 8'h00, 8'h00, 8'h00};
        expq = '{8'h04, 8'h00, 8'h00, 8'h00, 8'h1C, 8'h00, 8'h00, 8'h00};
        run_pkt("div_200_7");

        pkt  = '{8'hA2, 8'h00, 8'h08, 8'h00, 8'h55, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        expq = '{8'h55, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_pkt("div_by0");

        pkt  = '{8'hA2, 8'h00, 8'h0C, 8'h00, 8'h64, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00,
                 8'h03, 8'h00, 8'h00, 8'h00};
        expq = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0A, 8'h00, 8'h00, 8'h00};
        run_pkt("div_extra_opnd");

        pkt  = '{8'hA2, 8'h00, 8'h04, 8'h00, 8'h12, 8'h00, 8'h00, 8'h00};
        expq = '{8'h12, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
        run_pkt("div_one_opnd");

        pkt  = '{8'hA0, 8'h00, 8'h06, 8'h00, 8'h10, 8'h20, 8'h30, 8'h40, 8'h99, 8'h99};
        expq = '{8'h10, 8'h20, 8'h30, 8'h40};
        run_pkt("add_trailing");

        pkt  = '{8'hA0, 8'h00, 8'h00, 8'h00};
        expq = '{8'h00, 8'h00, 8'h00, 8'h00};
        run_pkt("add_len0");

        pkt  = '{8'hA1, 8'h00, 8'h00, 8'h00};
        expq = '{8'h01, 8'h00, 8'h00, 8'h00};
        run_pkt("mul_len0");

        pkt = '{8'hEC, 8'h00, 8'h00, 8'h00};
        foreach (pkt[i]) send_byte(pkt[i]);
        expect_silence("echo_len0_silent");

        pkt = '{8'h33, 8'h00, 8'h03, 8'h00, 8'h11, 8'h22, 8'h33};
        foreach (pkt[i]) send_byte(pkt[i]);
        expect_silence("unknown_silent");
        pkt  = '{8'hEC, 8'h00, 8'h02, 8'h00, 8'hAA, 8'h55};
        expq = '{8'hAA, 8'h55};
        run_pkt("echo_after_unknown");

        // Framing error: 0xEC with a low stop bit must be dropped.
        rb = 8'hEC;
        u_if.rx_i = 1'b0;
        repeat (BIT) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            u_if.rx_i = rb[i];
            repeat (BIT) @(negedge clk);
        end
        u_if.rx_i = 1'b0;
        repeat (2 * BIT) @(negedge clk);
        u_if.rx_i = 1'b1;
        repeat (3 * BIT) @(negedge clk);
        pkt  = '{8'hEC, 8'h00, 8'h01, 8'h00, 8'h77};
        expq = '{8'h77};
        run_pkt("echo_after_frame_err");

        // Reset in the middle of a transmitted frame.
        pkt = '{8'hEC, 8'h00, 8'h01, 8'h00, 8'h00};
        foreach (pkt[i]) send_byte(pkt[i]);
        budget = 0;
        while (u_if.tx_o !== 1'b0 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        repeat (6) @(negedge clk);
        chk("tx_mid_frame_low", 64'(u_if.tx_o), 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("tx_high_after_reset", 64'(u_if.tx_o), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (60) @(negedge clk);
        rxq.delete();

        // Reset in the middle of an ADD payload byte.
        pkt = '{8'hA0, 8'h00, 8'h08, 8'h00, 8'h11, 8'h22};
        foreach (pkt[i]) send_byte(pkt[i]);
        u_if.rx_i = 1'b0;
        repeat (BIT) @(negedge clk);
        u_if.rx_i = 1'b1;
        repeat (BIT) @(negedge clk);
        u_if.rx_i = 1'b0;
        repeat (BIT) @(negedge clk);
        rst = 1'b1;
        u_if.rx_i = 1'b1;
        @(negedge clk);
        chk("tx_high_reset_payload", 64'(u_if.tx_o), 64'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        expect_silence("reset_payload_silent");
        pkt  = '{8'hEC, 8'h00, 8'h02, 8'h00, 8'h5A, 8'hC3};
        expq = '{8'h5A, 8'hC3};
        run_pkt("echo_after_reset");

        for (int it = 0; it < 100; it++) begin
            sel = $urandom_range(0, 3);
            pkt.delete();
            expq.delete();
            if (sel == 0) begin
                n = $urandom_range(1, 3);
                pkt = '{8'hEC, 8'h00, byte_t'(n), 8'h00};
                for (int i = 0; i < n; i++) begin
                    rb = byte_t'($urandom_range(1, 255));
                    pkt.push_back(rb);
                    expq.push_back(rb);
                end
            end else if (sel == 3) begin
                a = {byte_t'($urandom_range(1, 255)), byte_t'($urandom_range(1, 255)),
                     byte_t'($urandom_range(1, 255)), byte_t'($urandom_range(1, 255))};
                b = {24'd0, byte_t'($urandom_range(1, 255))};
                q = a / b;
                r = a % b;
                pkt = '{8'hA2, 8'h00, 8'h08, 8'h00};
                for (int i = 0; i < 4; i++) pkt.push_back(a[8*i +: 8]);
                for (int i = 0; i < 4; i++) pkt.push_back(b[8*i +: 8]);
                for (int i = 0; i < 4; i++) expq.push_back(r[8*i +: 8]);
                for (int i = 0; i < 4; i++) expq.push_back(q[8*i +: 8]);
            end else begin
                nops  = $urandom_range(0, 2);
                trail = $urandom_range(0, 1);
                acc   = (sel == 1) ? 32'd0 : 32'd1;
                pkt = '{(sel == 1) ? 8'hA0 : 8'hA1, 8'h00, byte_t'(4 * nops + trail), 8'h00};
                for (int k = 0; k < nops; k++) begin
                    for (int i = 0; i < 4; i++) opnd[8*i +: 8] = byte_t'($urandom_range(1, 255));
                    for (int i = 0; i < 4; i++) pkt.push_back(opnd[8*i +: 8]);
                    if (sel == 1) acc = acc + opnd;
                    else          acc = acc * opnd;
                end
                for (int i = 0; i < trail; i++) pkt.push_back(byte_t'($urandom_range(1, 255)));
                for (int i = 0; i < 4; i++) expq.push_back(acc[8*i +: 8]);
            end
            run_pkt("rand");
        end

        repeat (100) @(negedge clk);
        chk("no_stray_bytes", 64'(rxq.size()), 64'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/uart_alu_runner.md
Name: uart_alu_runner

Overview:
- UART-attached packet processor.
- Receives framed command packets on a serial RX line, decodes the opcode, and either echoes the payload or runs a 32-bit ALU operation (add, multiply, divide) over little-endian operands.
- Returns the result bytes on a serial TX line.
- Top-level block between the board UART pins and the ALU datapath; contains the UART RX/TX, the packet parser and the ALU.

Parameters:
- CLK_FREQ_HZ, 100000000, system clock frequency.
- BAUD_RATE, 115200, serial bit rate; bit period = CLK_FREQ_HZ/BAUD_RATE cycles (integer, truncated).
- TX_FIFO_DEPTH, 16, byte depth of transmit FIFO (power of 2).

Ports:
- clk_i  input  1  system clock; all logic on rising edge.
- reset_i  input  1  synchronous, active-high reset.
- rx_i  input  1  UART receive line, idle high, asynchronous to clk_i.
- tx_o  output  1  UART transmit line, idle high.

Behaviour:
- Serial format: 8N1, LSB first, idle high. rx_i passes through a 2-flop synchronizer.
- RX start detection:
  - A falling edge starts reception; the start bit is re-sampled at mid-bit and, if high, the start is discarded.
  - Data bits are sampled at mid-bit.
  - If the stop bit samples low (framing error), the byte is dropped and RX waits for the line to return high.
- TX: transmits bytes from the FIFO back-to-back (start, 8 data, 1 stop). When the FIFO is full, the parser stalls; RX bytes are never lost during echo at equal baud.
- Packet format, in byte order: opcode, reserved (ignored, value 0x00), length_lsb, length_msb, then payload.
  - The 16-bit length = payload byte count (header excluded).
  - Operands are 32-bit little-endian: payload[4k] is the LSB of operand k.
- Parser FSM states: OPCODE, RESERVED, LEN_LO, LEN_HI, PAYLOAD, COMPUTE, RESPOND, DISCARD.
- Opcode 0xEC ECHO: each payload byte is pushed to the TX FIFO as received. Response = payload bytes in order. Length 0 gives no response.
- Opcode 0xA0 ADD:
  - acc starts at 0; acc = acc + operand, mod 2^32, unsigned.
  - Response = 4 bytes of acc, LSB first.
- Opcode 0xA1 MUL:
  - acc starts at 1; acc = low 32 bits of acc*operand, unsigned.
  - Response = 4 bytes, LSB first.
- Opcode 0xA2 DIV:
  - A = operand 0, B = operand 1; operands beyond 2 are ignored.
  - Unsigned iterative restoring divider: 32 cycles, start to done.
  - Response = 8 bytes: remainder (4 bytes LSB first), then quotient (4 bytes LSB first).
  - B = 0: quotient = 0xFFFFFFFF, remainder = A.
  - Fewer than 2 operands: missing operands read as 0.
- ALU length rules: trailing bytes not forming a full operand are ignored. Zero operands: ADD returns 0x00000000, MUL returns 0x00000001.
- ALU sequencing: the response is queued only after the last payload byte is received and the computation completes. ADD/MUL accumulate per operand as its fourth byte arrives.
- Unknown opcode: enter DISCARD, consume `length` payload bytes, no response, return to OPCODE.
- Packet boundary: after a response is fully pushed into the FIFO, the FSM returns to OPCODE; the next packet may begin while TX drains.
- Reset:
  - tx_o = 1, FIFO empty, FSM = OPCODE, accumulators = 0, RX/TX idle.
  - Reset mid-packet or mid-transmission aborts immediately; tx_o goes high the cycle after reset is sampled.
  - Any partial RX byte is discarded.

Test Plan:
- Echo, 16 bytes 0x01..0x10, length 0x0010 -> tx returns 0x01..0x10 in order; 0 byte errors.
- ADD with operands 0x000000FF, 0x00000002, 0x80000001, 0x7FFFFFFF -> response bytes 0x01 0x01 0x00 0x00 (sum 0x00000101, wrap mod 2^32).
- MUL with operands 3, 5, 7, 1 (length 16) -> 0x69 0x00 0x00 0x00. Also 0x10000, 0x10000, 1, 1 -> 0x00000000 (truncation).
- DIV, length 8, A = 0x000000C8 (200), B = 0x00000007 -> bytes 0x04 0x00 0x00 0x00 | 0x1C 0x00 0x00 0x00 (remainder 4, quotient 28). B = 0 with A = 0x55 -> 0x55 0x00 0x00 0x00 | 0xFF 0xFF 0xFF 0xFF.
- Unknown opcode 0x33, length 3, then echo packet of 2 bytes 0xAA 0x55 -> only 0xAA 0x55 transmitted.
- Reset asserted mid-payload of an ADD packet, then a fresh 100-iteration random ECHO/ADD/MUL/DIV run (operand bytes 0x01..0xFF, DIV divisor bytes 1..3 = 0) -> tx_o high after reset, all results match unsigned reference model, 0 errors.
